// File: rtl/seq_0001_gen.sv
// ---------------------------------------------------------------------------
// seq_0001_gen
// Serial pattern generator. On a start request it transmits rep_cnt frames
// of PATTERN (MSB first) on x, separated by a one-cycle idle gap, then
// pulses done for one cycle. Receiver back-pressure (ready=0) freezes the
// line, and abort cancels the transmission without a done pulse.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-low reset
//   start    in   request a transmission (sampled only in IDLE)
//   rep_cnt  in   [REP_W-1:0] number of frames, captured with start
//   ready    in   receiver can accept a bit; low stalls shifting
//   abort    in   cancel the transmission in progress
//   x        out  serial line, idle level 1
//   x_vld    out  x carries a pattern bit this cycle
//   busy     out  transmission in progress
//   done     out  one-cycle pulse after the last frame
// ---------------------------------------------------------------------------
module seq_0001_gen #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0001,
    parameter int                 REP_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic             ready,
    input  logic             abort,
    output logic             x,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [REP_W-1:0]   frames;
    logic [IDX_W-1:0]   idx;
    // Holds the bits still to be sent after the one currently on x,
    // left-aligned so the next bit is always the MSB.
    logic [PAT_LEN-1:0] shreg;

    // Single-process Moore FSM: every output is a register updated together
    // with the state, so each output reflects the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            frames <= '0;
            idx    <= '0;
            shreg  <= '0;
            x      <= 1'b1;
            x_vld  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x     <= 1'b1;
                    x_vld <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        if (rep_cnt != '0) begin
                            frames <= rep_cnt;
                            idx    <= '0;
                            shreg  <= PATTERN << 1;
                            x      <= PATTERN[PAT_LEN-1];
                            x_vld  <= 1'b1;
                            busy   <= 1'b1;
                            state  <= SHIFT;
                        end else begin
                            // Zero frames requested: report completion
                            // immediately without touching the line.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        frames <= '0;
                        idx    <= '0;
                        x      <= 1'b1;
                        x_vld  <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (ready) begin
                        if (idx == LAST_IDX) begin
                            // Frame complete; the counter saturates at zero.
                            frames <= (frames != '0) ? frames - REP_W'(1) : frames;
                            idx    <= '0;
                            x      <= 1'b1;
                            x_vld  <= 1'b0;
                            if (frames > REP_W'(1)) begin
                                state <= GAP;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            x     <= shreg[PAT_LEN-1];
                            shreg <= shreg << 1;
                        end
                    end
                end

                GAP: begin
                    // The gap always lasts one cycle regardless of ready.
                    if (abort) begin
                        frames <= '0;
                        idx    <= '0;
                        x      <= 1'b1;
                        x_vld  <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx   <= '0;
                        shreg <= PATTERN << 1;
                        x     <= PATTERN[PAT_LEN-1];
                        x_vld <= 1'b1;
                        state <= SHIFT;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    x     <= 1'b1;
                    x_vld <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_0001_gen.md
SEQ_0001_GEN -- requirements
Module: seq_0001_gen

Interface
REQ-001 Parameter PAT_LEN, default 4: number of bits in one pattern frame (2..16).
REQ-002 Parameter PATTERN, default 4'b0001: frame bits, transmitted MSB first, so the default frame is 0,0,0,1.
REQ-003 Parameter REP_W, default 4: width of the repeat-count input.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 start  input  1  request a transmission; sampled only in IDLE.
REQ-007 rep_cnt  input  REP_W  number of frames to send; captured with start.
REQ-008 ready  input  1  receiver may accept a bit; low stalls shifting.
REQ-009 abort  input  1  cancel the transmission in progress.
REQ-010 x  output  1  serial line, registered; idle level is 1.
REQ-011 x_vld  output  1  x carries a pattern bit this cycle.
REQ-012 busy  output  1  transmission in progress.
REQ-013 done  output  1  one-cycle pulse when all frames have been sent.

Function
REQ-014 FSM states SHALL be: IDLE, SHIFT, GAP, DONE. All outputs SHALL be registered Moore outputs.
REQ-015 IDLE behaviour: x=1, x_vld=0, busy=0, done=0.
REQ-016 IDLE, start=1, rep_cnt>0: at that edge SHALL latch rep_cnt, load PATTERN, enter SHIFT. First bit appears on x the cycle after start is sampled, with x_vld=1 and busy=1.
REQ-017 IDLE, start=1, rep_cnt=0: SHALL go to DONE with no bits sent, so done pulses the next cycle.
REQ-018 SHIFT: x = current frame bit, x_vld=1. With ready=1 the bit index advances each cycle. With ready=0, x, x_vld and the index SHALL hold unchanged.
REQ-019 After the last bit (LSB) is accepted:
  - frames remaining > 0: go to GAP for exactly one cycle (x=1, x_vld=0, busy=1), then reload PATTERN and return to SHIFT.
  - last frame: go to DONE.
REQ-020 The GAP cycle SHALL ignore ready.
REQ-021 DONE SHALL last one cycle: done=1, busy=0, x=1, x_vld=0, then IDLE.
REQ-022 Frame counter SHALL be REP_W bits, decrement once per completed frame, and never wrap below zero.
REQ-023 start while busy or in DONE SHALL be ignored and not queued.
REQ-024 abort=1 in SHIFT or GAP: next cycle SHALL be IDLE (x=1, x_vld=0, busy=0); done SHALL NOT pulse.
REQ-025 abort=1 in IDLE or DONE SHALL have no effect.
REQ-026 abort and ready both active: abort SHALL take priority.
REQ-027 Total active duration with ready held high SHALL be rep_cnt*PAT_LEN + (rep_cnt-1) cycles, followed by the done cycle.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE and: x=1, x_vld=0, busy=0, done=0, frame counter=0, bit index=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame without a done pulse.
REQ-030 After rst returns to 1, the block SHALL accept start on the first sampled edge.

Verification
REQ-031 rst=0 for 2 cycles, then rst=1 with start=0 -> x=1, x_vld=0, busy=0, done=0 held.
REQ-032 start=1 at cycle k, rep_cnt=1, ready=1:
  - cycles k+1..k+4: x = 0,0,0,1 with x_vld=1.
  - cycle k+5: done=1, busy=0.
REQ-033 start at cycle k, rep_cnt=2, ready=1:
  - cycles k+1..k+4: x = 0,0,0,1.
  - cycle k+5: x=1, x_vld=0 (GAP).
  - cycles k+6..k+9: x = 0,0,0,1.
  - cycle k+10: done=1.
  - A connected seq_0001 detector SHALL assert z twice.
REQ-034 rep_cnt=1, ready=0 for 3 cycles during the second bit -> x=0 held for 4 cycles total; frame still completes 0,0,0,1; done delayed by 3 cycles.
REQ-035 rep_cnt=3, abort=1 during the second frame -> IDLE next cycle with x=1, busy=0, no done. A start applied later SHALL begin a fresh frame.
REQ-036 start with rep_cnt=0 -> done=1 next cycle and x_vld never asserted. A start pulsed during busy SHALL not extend the transmission.
